latch_write_arbiter: RTL and testbench
======================================

Name: latch_write_arbiter

Overview:
- Arbitrates write access to one shared W-bit transparent latch (level-sensitive: q follows d while ena=1, holds while ena=0) among NREQ requesters.
- Registers the winner's data and sequences the latch enable: a fixed open window, then a guard cycle in which data is held stable after ena falls, then an acknowledge.
- Sits between requesting agents and the external latch; the latch itself is outside this block.

Parameters:
- NREQ, 4, number of requesters (2..16)
- W, 8, latch data width
- OPEN_CYC, 2, cycles lat_ena is held high per write (>=1)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request, level
- req_data  input  NREQ*W  flattened data; requester i at [i*W +: W]
- gnt  output  NREQ  one-hot grant, registered
- ack  output  NREQ  one-hot write-complete pulse, one cycle
- lat_d  output  W  data to latch d
- lat_ena  output  1  latch enable
- busy  output  1  high in OPEN or CLOSE

Behaviour:
- Reset (sync, active-high, dominates everything):
  - state=IDLE, gnt=0, ack=0, lat_ena=0, lat_d=0, busy=0.
  - Round-robin pointer=0; window counter=0.
- States: IDLE, OPEN, CLOSE.
- IDLE:
  - If req!=0, winner = first set bit scanning from ptr upward, circular modulo NREQ.
  - Next edge: state=OPEN, gnt=onehot(winner), lat_d=req_data[winner], lat_ena=1, counter=OPEN_CYC-1.
  - If req==0, remain in IDLE; all outputs 0 except lat_d, which holds its last value.
- OPEN:
  - lat_ena=1; lat_d and gnt stable.
  - Counter decrements each cycle. When counter==0, next edge: state=CLOSE, lat_ena=0.
  - lat_ena is high for exactly OPEN_CYC cycles.
- CLOSE (one cycle):
  - lat_ena=0; lat_d still held (hold guard); gnt still asserted; ack=onehot(winner).
  - Next edge: state=IDLE, gnt=0, ack=0, ptr=(winner+1) mod NREQ.
- Latency:
  - req sampled high in an IDLE cycle t -> lat_ena high from t+1.
  - ack at t+OPEN_CYC+1.
  - Back in IDLE at t+OPEN_CYC+2.
- Throughput: one write per OPEN_CYC+2 cycles.
- Requester handshake: holds req until it sees ack; drops req the cycle after ack.
- Data is captured at grant. Changes to req_data or deassertion of req after grant do not affect the write; it completes and ack is still issued.
- The grant is never preempted. Requests arriving during OPEN/CLOSE wait for IDLE.
- Simultaneous requests: exactly one winner per arbitration; gnt and ack are always one-hot or zero.
- Reset mid-OPEN/CLOSE: write is aborted, no ack is issued, and all outputs return to reset values on that edge.
- Counter width: $clog2(OPEN_CYC+1).

Optional Feature:
- Macro: LATCH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; ptr is not used and is not updated.
- Undefined (default): round-robin as specified above.
- Timing, handshake and outputs are identical in both modes.

Test Plan (NREQ=4, W=8, OPEN_CYC=2):
- Reset held 2 cycles while req=4'b1111 -> gnt, ack, lat_ena, lat_d, busy all 0; first grant after release goes to requester 0.
- req=4'b0010, req_data[15:8]=8'hA5 at cycle 0:
  - cycles 1-2: lat_ena=1, gnt=4'b0010, lat_d=8'hA5;
  - cycle 3: lat_ena=0, lat_d=8'hA5, ack=4'b0010;
  - cycle 4: IDLE, gnt=0.
- req=4'b1111 held continuously (each requester dropping only one cycle after its ack), req_data[i]=8'h10+i -> grants in order 0,1,2,3,0 every 4 cycles; lat_d sequence 10,11,12,13,10.
- req=4'b0100 with data 8'h3C; after grant, req drops and data changes to 8'hFF -> lat_d stays 8'h3C for the full window; ack=4'b0100 still issued.
- reset asserted during the second OPEN cycle -> next edge lat_ena=0, gnt=0, no ack for that write; with req=4'b0110 after release, requester 1 wins.
- With LATCH_ARB_FIXED_PRIO_EN defined, req=4'b1111 held -> every grant goes to requester 0; with req=4'b1010, requester 1 always wins.

Source files
------------

// File: rtl/latch_write_arbiter.sv
// Arbitrates write access to one external transparent latch among NREQ requesters and
// sequences its enable: OPEN_CYC-cycle open window, one hold/ack cycle, back to idle.
// Define LATCH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module latch_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 8,
  parameter int OPEN_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      lat_d,
  output logic              lat_ena,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(OPEN_CYC + 1);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t          state, state_next;
  logic [NREQ-1:0] gnt_next, ack_next;
  logic [W-1:0]    lat_d_next;
  logic            lat_ena_next;
  logic [IW-1:0]   ptr, ptr_next;
  logic [IW-1:0]   win, win_next;
  logic [IW-1:0]   pick;
  logic            found;
  logic [CW-1:0]   cnt, cnt_next;
  int              idx;

  // Winner selection, evaluated every cycle but only consumed in IDLE.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    pick  = '0;
    found = 1'b0;
    idx   = 0;
`ifdef LATCH_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    ack_next     = '0;
    lat_d_next   = lat_d;
    lat_ena_next = lat_ena;
    ptr_next     = ptr;
    win_next     = win;
    cnt_next     = cnt;
    unique case (state)
      IDLE: begin
        gnt_next     = '0;
        lat_ena_next = 1'b0;
        if (found) begin
          state_next   = OPEN;
          gnt_next     = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          lat_d_next   = req_data[pick*W +: W];
          lat_ena_next = 1'b1;
          cnt_next     = CW'(OPEN_CYC - 1);
          win_next     = pick;
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_next   = CLOSE;
          lat_ena_next = 1'b0;
          ack_next     = gnt;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      CLOSE: begin
        // lat_d is left untouched here so the latch input stays stable after ena falls.
        state_next = IDLE;
        gnt_next   = '0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
        ptr_next   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      lat_d   <= '0;
      lat_ena <= 1'b0;
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      ack     <= ack_next;
      lat_d   <= lat_d_next;
      lat_ena <= lat_ena_next;
      ptr     <= ptr_next;
      win     <= win_next;
      cnt     <= cnt_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed self-checking bench for latch_write_arbiter (NREQ=4, W=8, OPEN_CYC=2).
// Outputs are packed as {gnt, ack, lat_ena, busy, lat_d} and compared mid-cycle.
module tb_latch_write_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt, ack;
  logic [W-1:0]      lat_d;
  logic              lat_ena, busy;
  logic [17:0]       obs;
  logic [17:0]       exp_v;

  int vectors     = 0;
  int miscompares = 0;

  latch_write_arbiter #(.NREQ(NREQ), .W(W), .OPEN_CYC(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .lat_d    (lat_d),
    .lat_ena  (lat_ena),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, ack, lat_ena, busy, lat_d};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_data = '0;
    step();
    vectors++;
    if (obs !== 18'h0) begin miscompares++; $display("FAIL reset_c0 got=%h exp=%h", obs, 18'h0); end
    step();
    vectors++;
    if (obs !== 18'h0) begin miscompares++; $display("FAIL reset_c1 got=%h exp=%h", obs, 18'h0); end
    reset = 1'b0;
    step();
    exp_v = {4'b0001, 4'b0000, 1'b1, 1'b1, 8'h00};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_first_grant got=%h exp=%h", obs, exp_v); end
    req = '0;
    step();
    step();
    exp_v = {4'b0001, 4'b0001, 1'b0, 1'b1, 8'h00};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_first_ack got=%h exp=%h", obs, exp_v); end
    step();
    vectors++;
    if (obs !== 18'h0) begin miscompares++; $display("FAIL reset_first_idle got=%h exp=%h", obs, 18'h0); end
  endtask

  task automatic test_single();
    req_data = '0; req_data[15:8] = 8'hA5; req = 4'b0010;
    step();
    exp_v = {4'b0010, 4'b0000, 1'b1, 1'b1, 8'hA5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL single_c1 got=%h exp=%h", obs, exp_v); end
    step();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL single_c2 got=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'b0010, 4'b0010, 1'b0, 1'b1, 8'hA5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL single_c3_ack got=%h exp=%h", obs, exp_v); end
    req = '0;
    step();
    exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL single_c4_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_round_robin();
    int         exp_i;
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
      exp_i = 0;
`else
      exp_i = k % 4;
`endif
      exp_oh = 4'(4'b0001 << exp_i);
      exp_d  = 8'(8'h10 + exp_i);
      step();
      exp_v = {exp_oh, 4'b0000, 1'b1, 1'b1, exp_d};
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL rr_grant%0d got=%h exp=%h", k, obs, exp_v); end
      step();
      step();
      exp_v = {exp_oh, exp_oh, 1'b0, 1'b1, exp_d};
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL rr_ack%0d got=%h exp=%h", k, obs, exp_v); end
      if (k == 4) req = '0;
      step();
      exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, exp_d};
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL rr_idle%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_data_capture();
    req_data = '0; req_data[23:16] = 8'h3C; req = 4'b0100;
    step();
    exp_v = {4'b0100, 4'b0000, 1'b1, 1'b1, 8'h3C};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL capture_c1 got=%h exp=%h", obs, exp_v); end
    req = '0; req_data = '1;
    step();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL capture_c2 got=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'b0100, 4'b0100, 1'b0, 1'b1, 8'h3C};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL capture_ack got=%h exp=%h", obs, exp_v); end
    step();
    exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'h3C};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL capture_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    req_data = {8'h5A, 8'h22, 8'h11, 8'h00}; req = 4'b1000;
    step();
    exp_v = {4'b1000, 4'b0000, 1'b1, 1'b1, 8'h5A};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL mid_c1 got=%h exp=%h", obs, exp_v); end
    req = '0;
    step();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL mid_c2 got=%h exp=%h", obs, exp_v); end
    reset = 1'b1;
    step();
    vectors++;
    if (obs !== 18'h0) begin miscompares++; $display("FAIL mid_abort got=%h exp=%h", obs, 18'h0); end
    reset = 1'b0; req = 4'b0110;
    step();
    exp_v = {4'b0010, 4'b0000, 1'b1, 1'b1, 8'h11};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL mid_regrant got=%h exp=%h", obs, exp_v); end
    req = '0;
    step();
    step();
    exp_v = {4'b0010, 4'b0010, 1'b0, 1'b1, 8'h11};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL mid_ack got=%h exp=%h", obs, exp_v); end
    step();
  endtask

  task automatic test_back_to_back();
    int         exp_i;
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
      exp_i = 1;
`else
      exp_i = (k == 1) ? 1 : 3;
`endif
      exp_oh = 4'(4'b0001 << exp_i);
      exp_d  = (exp_i == 3) ? 8'h5A : 8'h11;
      step();
      exp_v = {exp_oh, 4'b0000, 1'b1, 1'b1, exp_d};
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL b2b_grant%0d got=%h exp=%h", k, obs, exp_v); end
      step();
      step();
      exp_v = {exp_oh, exp_oh, 1'b0, 1'b1, exp_d};
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL b2b_ack%0d got=%h exp=%h", k, obs, exp_v); end
      if (k == 2) req = '0;
      step();
      exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, exp_d};
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL b2b_idle%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_data_capture();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
